// File: rtl/conf_int_add_operand_stager.sv
// rtl/conf_int_add_operand_stager.sv - 2-entry operand FIFO with MSB truncation, feeding the integer adder
// Precision changes wait for the FIFO to drain so no stored pair mixes precisions.
module conf_int_add_operand_stager #(
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int PREC_W             = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
  input  logic                          cfg_load,
  input  logic [PREC_W-1:0]             prec_cfg,
  output logic                          cfg_pending,
  output logic [PREC_W-1:0]             prec_active,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] a_out,
  output logic [DATA_PATH_BITWIDTH-1:0] b_out,
  output logic [15:0]                   pair_count
);

  localparam int W = DATA_PATH_BITWIDTH;
  localparam logic [PREC_W-1:0] FULL_PREC = PREC_W'(W);

  logic [1:0]        count;
  logic [W-1:0]      head_a, head_b, tail_a, tail_b;
  logic [PREC_W-1:0] prec_pend;
  logic [PREC_W-1:0] eff;
  logic [W-1:0]      mask, a_m, b_m;
  logic              enq, deq;

  // Keep the top eff bits; a shift of W or more clears the shifted pattern, giving an all-ones mask.
  always_comb begin
    eff  = (prec_active > FULL_PREC) ? FULL_PREC : prec_active;
    mask = ~({W{1'b1}} >> eff);
    a_m  = in_a & mask;
    b_m  = in_b & mask;
  end

  assign in_ready  = ~count[1] & ~cfg_pending;
  assign out_valid = (count != 2'd0);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;
  assign a_out     = head_a;
  assign b_out     = head_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= 2'd0;
      head_a      <= '0;
      head_b      <= '0;
      tail_a      <= '0;
      tail_b      <= '0;
      cfg_pending <= 1'b0;
      prec_pend   <= '0;
      prec_active <= FULL_PREC;
      pair_count  <= 16'd0;
    end else begin
      case (count)
        2'd0: begin
          if (enq) begin
            head_a <= a_m;
            head_b <= b_m;
            count  <= 2'd1;
          end
        end
        2'd1: begin
          if (enq && deq) begin
            head_a <= a_m;
            head_b <= b_m;
          end else if (enq) begin
            tail_a <= a_m;
            tail_b <= b_m;
            count  <= 2'd2;
          end else if (deq) begin
            // Head reads as zero whenever the FIFO is empty.
            head_a <= '0;
            head_b <= '0;
            count  <= 2'd0;
          end
        end
        default: begin
          if (deq) begin
            head_a <= tail_a;
            head_b <= tail_b;
            tail_a <= '0;
            tail_b <= '0;
            count  <= 2'd1;
          end
        end
      endcase

      if (deq)
        pair_count <= pair_count + 16'd1;

      // A load arriving on the apply edge supersedes the held value.
      if (cfg_pending && (count == 2'd0)) begin
        prec_active <= cfg_load ? prec_cfg : prec_pend;
        cfg_pending <= 1'b0;
      end else if (cfg_load) begin
        prec_pend   <= prec_cfg;
        cfg_pending <= 1'b1;
      end
    end
  end

endmodule
